alu_mul_sequencer: RTL and testbench

Multi-cycle controller that drives the ArithmeticLogicUnit as its initiator to compute an unsigned 16x16 -> 32-bit product by shift-and-add. It owns the ALU operand, function-select and flag-write inputs, and consumes ALUOut and FlagsOut. The datapath top uses it as a hardware multiply engine, with the ALU muxed to it while Busy is high.

---
 rtl/alu_mul_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16 -> 32 unsigned multiplier that drives an external ALU.
// The ALU operand/function outputs are decoded combinationally from the current
// state and registers, because the ALU result must come back within the same cycle.
module alu_mul_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] MulA,
    input  logic [15:0] MulB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Product,
    output logic        Err,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    input  logic [31:0] AluOut,
    input  logic [3:0]  AluFlags
);

    localparam int unsigned OP_W  = 16;
    localparam int unsigned ALU_W = 32;
    localparam int unsigned FS_W  = 5;
    localparam int unsigned CNT_W = 5;

    localparam logic [FS_W-1:0]  FS_ADD  = 5'b10100;
    localparam logic [FS_W-1:0]  FS_LSL  = 5'b11011;
    localparam logic [FS_W-1:0]  FS_IDLE = 5'b10000;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OP_W);
    localparam int unsigned      FLAG_C = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [ALU_W-1:0]  m;
    logic [OP_W-1:0]   q;
    logic [ALU_W-1:0]  p;
    logic [CNT_W-1:0]  cnt;
    logic              add_done;

    logic              accept_c;
    logic              add_c;
    logic              shift_c;
    logic              last_c;

    // Only the carry flag is inspected; the rest of the flag bus is intentionally ignored.
    logic              unused_flags;
    assign unused_flags = ^{AluFlags[3], AluFlags[1:0]};

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and ALU drive; idle drive is the default.
    always_comb begin
        state_n   = state;
        AluA      = '0;
        AluB      = '0;
        AluFunSel = FS_IDLE;
        AluWF     = 1'b0;
        accept_c  = 1'b0;
        add_c     = 1'b0;
        shift_c   = 1'b0;
        last_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    accept_c = 1'b1;
                    state_n  = S_ADD;
                end
            end
            S_ADD: begin
                if (q[0]) begin
                    add_c     = 1'b1;
                    AluA      = p;
                    AluB      = m;
                    AluFunSel = FS_ADD;
                    AluWF     = 1'b1;
                end
                state_n = S_SHIFT;
            end
            S_SHIFT: begin
                shift_c   = 1'b1;
                AluA      = m;
                AluFunSel = FS_LSL;
                last_c    = (cnt == CNT_W'(1));
                state_n   = last_c ? S_DONE : S_ADD;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, accumulate, shift, result and sticky carry check.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            m        <= '0;
            q        <= '0;
            p        <= '0;
            cnt      <= '0;
            add_done <= 1'b0;
            Product  <= '0;
            Err      <= 1'b0;
        end else begin
            if (accept_c) begin
                m   <= {16'b0, MulA};
                q   <= MulB;
                p   <= '0;
                cnt <= CNT_INIT;
                Err <= 1'b0;
            end
            if (state == S_ADD) begin
                add_done <= add_c;
                if (add_c) begin
                    p <= AluOut;
                end
            end
            if (shift_c) begin
                m   <= AluOut;
                q   <= q >> 1;
                cnt <= cnt - CNT_W'(1);
                if (add_done && AluFlags[FLAG_C]) begin
                    Err <= 1'b1;
                end
                if (last_c) begin
                    Product <= p;
                end
            end
        end
    end

    // Status outputs registered from the next state so they align with the state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            Busy <= (state_n == S_ADD) || (state_n == S_SHIFT);
            Done <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU model.
module tb_alu_mul_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [15:0] MulA;
    logic [15:0] MulB;
    logic        Busy;
    logic        Done;
    logic [31:0] Product;
    logic        Err;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [31:0] AluOut;
    logic [3:0]  AluFlags;

    int checks = 0;
    int failures = 0;

    int wf_count = 0;
    int inject_at = -1;
    logic inject_en = 1'b0;

    alu_mul_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .MulA(MulA), .MulB(MulB),
        .Busy(Busy), .Done(Done), .Product(Product), .Err(Err),
        .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
        .AluOut(AluOut), .AluFlags(AluFlags)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural ALU: combinational result for add and shift-left.
    always_comb begin
        case (AluFunSel)
            5'b10100: AluOut = AluA + AluB;
            5'b11011: AluOut = AluA << 1;
            default:  AluOut = 32'h0;
        endcase
    end

    // Registered flags {Z, C, N, O}; carry can be forced on a chosen add.
    always_ff @(posedge Clock or negedge Reset) begin
        logic [32:0] s;
        if (!Reset) begin
            AluFlags <= 4'h0;
        end else if (AluWF) begin
            s = {1'b0, AluA} + {1'b0, AluB};
            AluFlags <= {s[31:0] == 32'h0,
                         s[32] | (inject_en && (wf_count == inject_at)),
                         s[31],
                         (AluA[31] == AluB[31]) && (s[31] != AluA[31])};
            wf_count <= wf_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One multiply: returns result, Err at Done, latency, Busy cycles, ALU adds, pulse width ok.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           output logic [31:0] prod, output logic err,
                           output int lat, output int busy_n, output int wf_n,
                           output logic done_ok);
        int wf0;
        @(negedge Clock);
        MulA = a; MulB = b; Start = 1'b1;
        wf0 = wf_count;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        MulA = ~a; MulB = ~b;
        lat = 0; busy_n = 0;
        while (lat < 100) begin
            lat++;
            if (Busy) busy_n++;
            if (Done) break;
            @(negedge Clock);
        end
        prod = Product;
        err = Err;
        wf_n = wf_count - wf0;
        @(negedge Clock);
        done_ok = !Done && !Busy;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        int          adds;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] prod;
        logic        err;
        int          lat, busy_n, wf_n, n;
        logic        done_ok;
        logic        seen;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 2};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16};
        vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, 0};
        vecs[3] = '{16'h0001, 16'h0001, 32'h00000001, 1};
        vecs[4] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 1};
        vecs[5] = '{16'h8000, 16'h8000, 32'h40000000, 1};
        vecs[6] = '{16'h00FF, 16'h0100, 32'h0000FF00, 1};
        vecs[7] = '{16'hABCD, 16'h0003, 32'h00020367, 2};

        Reset = 1'b0; Start = 1'b0; MulA = 16'h0; MulB = 16'h0;
        repeat (3) @(negedge Clock);
        chk("reset_busy", 32'(Busy), 32'h0);
        chk("reset_done", 32'(Done), 32'h0);
        chk("reset_err", 32'(Err), 32'h0);
        chk("reset_product", Product, 32'h0);
        chk("reset_alu_a", AluA, 32'h0);
        chk("reset_alu_b", AluB, 32'h0);
        chk("reset_funsel", 32'(AluFunSel), 32'h10);
        chk("reset_wf", 32'(AluWF), 32'h0);
        Reset = 1'b1;
        @(negedge Clock);

        for (int i = 0; i < 8; i++) begin
            run_mul(vecs[i].a, vecs[i].b, prod, err, lat, busy_n, wf_n, done_ok);
            chk($sformatf("v%0d_product", i), prod, vecs[i].prod);
            chk($sformatf("v%0d_err", i), 32'(err), 32'h0);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
            chk($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'd32);
            chk($sformatf("v%0d_alu_adds", i), 32'(wf_n), 32'(vecs[i].adds));
            chk($sformatf("v%0d_done_pulse", i), 32'(done_ok), 32'h1);
        end

        // Start held high; operands change mid-run and must not affect the first result.
        @(negedge Clock);
        MulA = 16'd7; MulB = 16'd9; Start = 1'b1;
        repeat (5) @(negedge Clock);
        MulA = 16'd2; MulB = 16'd2;
        n = 0;
        while (!Done && n < 100) begin
            @(negedge Clock);
            n++;
        end
        chk("held_first_done", 32'(Done), 32'h1);
        chk("held_first_product", Product, 32'd63);
        @(negedge Clock);
        chk("held_done_ignores_start", Product, 32'd63);
        n = 0;
        while (!Busy && n < 5) begin
            @(negedge Clock);
            n++;
        end
        chk("held_second_accepted", 32'(Busy), 32'h1);
        Start = 1'b0;
        n = 0;
        while (!Done && n < 100) begin
            @(negedge Clock);
            n++;
        end
        chk("held_second_product", Product, 32'd4);
        @(negedge Clock);

        // Reset in the middle of a long run discards everything.
        @(negedge Clock);
        MulA = 16'hFFFF; MulB = 16'hFFFF; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (9) @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("midreset_busy", 32'(Busy), 32'h0);
        chk("midreset_product", Product, 32'h0);
        chk("midreset_done", 32'(Done), 32'h0);
        chk("midreset_funsel", 32'(AluFunSel), 32'h10);
        @(negedge Clock);
        Reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge Clock);
            if (Done || Busy) seen = 1'b1;
        end
        chk("midreset_no_activity", 32'(seen), 32'h0);
        run_mul(16'd2, 16'd3, prod, err, lat, busy_n, wf_n, done_ok);
        chk("after_reset_product", prod, 32'd6);
        chk("after_reset_latency", 32'(lat), 32'd33);

        // Forced carry on the first add sets a sticky Err, cleared by the next Start.
        inject_at = wf_count;
        inject_en = 1'b1;
        run_mul(16'd3, 16'd5, prod, err, lat, busy_n, wf_n, done_ok);
        inject_en = 1'b0;
        chk("inject_err_at_done", 32'(err), 32'h1);
        chk("inject_product", prod, 32'h0000000F);
        chk("inject_err_sticky_idle", 32'(Err), 32'h1);
        @(negedge Clock);
        MulA = 16'd1; MulB = 16'd1; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        chk("err_cleared_on_start", 32'(Err), 32'h0);
        n = 0;
        while (!Done && n < 100) begin
            @(negedge Clock);
            n++;
        end
        chk("post_inject_product", Product, 32'h1);
        chk("post_inject_err", 32'(Err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
